// File: rtl/bck_curr_writeback_if.sv
// Port bundle for the curr-buffer writer: result tokens in, read port, pass-close reports out.
// in_valid marks a one-cycle token with no ready/backpressure path; stall freezes the whole block,
// and rd_en gets rd_data/rd_valid exactly one unstalled cycle later.
interface bck_curr_writeback_if #(
    parameter int MAX_READ = 64,
    parameter int RN_W     = 6,
    parameter int AW       = 7
);
    logic                stall;
    logic                init_en;
    logic [RN_W-1:0]     init_read_num;
    logic                in_valid;
    logic [RN_W-1:0]     in_read_num;
    logic                in_keep;
    logic                in_end_of_pass;
    logic [63:0]         in_x0;
    logic [63:0]         in_x1;
    logic [63:0]         in_x2;
    logic [63:0]         in_info;
    logic                rd_en;
    logic [RN_W-1:0]     rd_read_num;
    logic [AW-1:0]       rd_addr;
    logic [255:0]        rd_data;
    logic                rd_valid;
    logic                pass_done;
    logic [RN_W-1:0]     pass_read_num;
    logic [AW-1:0]       pass_size;
    logic                read_finish;
    logic [MAX_READ-1:0] overflow;

    modport master (
        output stall, init_en, init_read_num, in_valid, in_read_num, in_keep, in_end_of_pass,
               in_x0, in_x1, in_x2, in_info, rd_en, rd_read_num, rd_addr,
        input  rd_data, rd_valid, pass_done, pass_read_num, pass_size, read_finish, overflow
    );

    modport slave (
        input  stall, init_en, init_read_num, in_valid, in_read_num, in_keep, in_end_of_pass,
               in_x0, in_x1, in_x2, in_info, rd_en, rd_read_num, rd_addr,
        output rd_data, rd_valid, pass_done, pass_read_num, pass_size, read_finish, overflow
    );
endinterface

// File: rtl/bck_curr_writeback.sv
// Writer side of the backward-extension curr buffer: per-read ping-pong banks, append of kept
// intervals, bank swap and size publication at pass end, and the 1-cycle read port.
module bck_curr_writeback #(
    parameter int MAX_READ = 64,
    parameter int RN_W     = 6,
    parameter int DEPTH    = 64,
    parameter int AW       = 7
) (
    input logic               clk,
    input logic               rst,
    bck_curr_writeback_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int MW = RN_W + 1 + IW;

    logic [255:0]        mem [0:(1<<MW)-1];
    logic [AW-1:0]       new_size  [MAX_READ];
    logic [AW-1:0]       last_size [MAX_READ];
    logic [MAX_READ-1:0] bank_sel;
    logic [MAX_READ-1:0] overflow_q;

    logic [255:0]    rd_data_q;
    logic            rd_valid_q;
    logic            pass_done_q;
    logic [RN_W-1:0] pass_read_num_q;
    logic [AW-1:0]   pass_size_q;
    logic            read_finish_q;

    logic            tok_go;
    logic [AW-1:0]   cur_size;
    logic            has_room;
    logic            wr_en;
    logic [AW-1:0]   size_after;
    logic [MW-1:0]   wr_addr;
    logic            rd_hit;
    logic [MW-1:0]   rd_mem_addr;

    // A same-slot init discards the token entirely, so it never reaches the counters or memory.
    always_comb begin
        tok_go      = bus.in_valid && !bus.stall &&
                      !(bus.init_en && (bus.init_read_num == bus.in_read_num));
        cur_size    = new_size[bus.in_read_num];
        has_room    = cur_size < AW'(DEPTH);
        wr_en       = tok_go && bus.in_keep && has_room;
        size_after  = cur_size + AW'(wr_en);
        wr_addr     = {bus.in_read_num, bank_sel[bus.in_read_num], cur_size[IW-1:0]};
        rd_hit      = bus.rd_en && (bus.rd_addr < last_size[bus.rd_read_num]);
        rd_mem_addr = {bus.rd_read_num, ~bank_sel[bus.rd_read_num], bus.rd_addr[IW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {bus.in_info, bus.in_x2, bus.in_x1, bus.in_x0};
        end
    end

    // Reads sample bank_sel/last_size before any same-cycle pass swap, so they see the prior pass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (!bus.stall) begin
            rd_valid_q <= rd_hit;
            rd_data_q  <= rd_hit ? mem[rd_mem_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MAX_READ; i++) begin
                new_size[i]  <= '0;
                last_size[i] <= '0;
            end
            bank_sel        <= '0;
            overflow_q      <= '0;
            pass_done_q     <= 1'b0;
            pass_read_num_q <= '0;
            pass_size_q     <= '0;
            read_finish_q   <= 1'b0;
        end else if (!bus.stall) begin
            pass_done_q   <= 1'b0;
            read_finish_q <= 1'b0;
            if (tok_go) begin
                if (bus.in_keep && !has_room) begin
                    overflow_q[bus.in_read_num] <= 1'b1;
                end
                if (bus.in_end_of_pass) begin
                    last_size[bus.in_read_num] <= size_after;
                    new_size[bus.in_read_num]  <= '0;
                    bank_sel[bus.in_read_num]  <= ~bank_sel[bus.in_read_num];
                    pass_done_q     <= 1'b1;
                    pass_read_num_q <= bus.in_read_num;
                    pass_size_q     <= size_after;
                    read_finish_q   <= (size_after == '0);
                end else begin
                    new_size[bus.in_read_num] <= size_after;
                end
            end
            if (bus.init_en) begin
                new_size[bus.init_read_num]   <= '0;
                last_size[bus.init_read_num]  <= '0;
                bank_sel[bus.init_read_num]   <= 1'b0;
                overflow_q[bus.init_read_num] <= 1'b0;
            end
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.pass_done     = pass_done_q;
    assign bus.pass_read_num = pass_read_num_q;
    assign bus.pass_size     = pass_size_q;
    assign bus.read_finish   = read_finish_q;
    assign bus.overflow      = overflow_q;
endmodule
